axil_master: RTL
================

# axil_master

AXI-Lite initiator that turns a single-outstanding request/response command port (core load/store or debug path) into AXI-Lite read and write transactions on the `cfg_*` bus. It drives the bus toward peripheral responders such as the GPIO block. It handles AW and W accepted in different cycles, holds each response until the requester takes it, and flags stalled handshakes with a sticky timeout.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: cycles to wait on any single bus handshake before `timeout_o` sets; 0 disables the watchdog.

Ports:
- `clk_i` in 1: system clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: command valid.
- `req_ready_o` out 1: command accepted when high with `req_valid_i`.
- `req_we_i` in 1: 1 = write, 0 = read.
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: write data.
- `req_wstrb_i` in 4: write byte strobes.
- `resp_valid_o` out 1: response valid.
- `resp_ready_i` in 1: requester takes the response.
- `resp_rdata_o` out 32: read data (0 for writes).
- `resp_err_o` out 1: bus returned SLVERR or DECERR.
- `timeout_o` out 1: sticky watchdog flag.
- `timeout_clr_i` in 1: clears `timeout_o`.
- `cfg_awvalid_o` out 1, `cfg_awready_i` in 1, `cfg_awaddr_o` out 32.
- `cfg_wvalid_o` out 1, `cfg_wready_i` in 1, `cfg_wdata_o` out 32, `cfg_wstrb_o` out 4.
- `cfg_bvalid_i` in 1, `cfg_bready_o` out 1, `cfg_bresp_i` in 2.
- `cfg_arvalid_o` out 1, `cfg_arready_i` in 1, `cfg_araddr_o` out 32.
- `cfg_rvalid_i` in 1, `cfg_rready_o` out 1, `cfg_rdata_i` in 32, `cfg_rresp_i` in 2.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE: `req_ready_o` = 1, decoded combinationally as state == IDLE. On handshake, latch addr, wdata and wstrb into the `cfg_*` output registers.
  - Write: set `cfg_awvalid_o` and `cfg_wvalid_o`, then go to WR_REQ.
  - Read: set `cfg_arvalid_o`, then go to RD_ADDR.
- WR_REQ: `aw_done` and `w_done` flags are tracked independently.
  - Each valid drops the cycle after its own valid&&ready sample.
  - When both are done (same cycle or different), go to WR_RESP and set `cfg_bready_o`.
- WR_RESP: on `cfg_bvalid_i` && `cfg_bready_o`:
  - `resp_err_o` = `cfg_bresp_i[1]`; `resp_rdata_o` = 0.
  - Drop bready, set `resp_valid_o`, go to RESP.
- RD_ADDR: on `cfg_arready_i`, drop arvalid, set `cfg_rready_o`, go to RD_DATA.
- RD_DATA: on `cfg_rvalid_i`:
  - Capture `cfg_rdata_i` into `resp_rdata_o`; `resp_err_o` = `cfg_rresp_i[1]`.
  - Drop rready, set `resp_valid_o`, go to RESP.
- RESP: hold all response outputs stable until `resp_ready_i`, then go to IDLE.
- Bus valids are never withdrawn before their handshake completes, as the AXI rule requires.
- `cfg_bvalid_i` arriving while AW or W is still pending is ignored, because bready stays 0.
- Watchdog:
  - A counter runs in WR_REQ, WR_RESP, RD_ADDR and RD_DATA, and resets on every bus handshake and on entering IDLE.
  - At `TIMEOUT_CYCLES` it sets `timeout_o`. The transaction is not aborted.
  - `timeout_clr_i` clears the flag. If a set condition and clear fall in the same cycle, set wins.

## Timing
- Reset (async assert, sync deassert is the system's job):
  - State = IDLE.
  - All `cfg_*valid_o` and `cfg_*ready_o` = 0.
  - `cfg_*addr_o`, `cfg_wdata_o`, `cfg_wstrb_o` = 0.
  - `resp_valid_o` = 0, `resp_rdata_o` = 0, `resp_err_o` = 0, `timeout_o` = 0.
  - `req_ready_o` = 1.
- Reset mid-transaction drops every valid immediately; the in-flight transaction is lost.
- Request handshake at cycle N puts the bus valids high at N+1.
- Best-case latency, with a responder that is always ready and answers in the next cycle:
  - Write: `resp_valid_o` at N+3.
  - Read: `resp_valid_o` at N+3.
- `req_ready_o` stays low from N+1 until the cycle after the response handshake.
- All outputs are registered except `req_ready_o`.

## Structure
- Shared package `axil_pkg`:
  - State enum.
  - Response codes: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11.
  - Address and data width constants (32).
- One sub-module, `axil_watchdog`: the counter plus the sticky flag, with ports `clk_i`, `rst_ni`, `run_i`, `kick_i`, `clr_i`, `flag_o`.

## Test plan
- Write to 0x08 with data 0xA5A5_0001, strobe 0xF, responder accepts AW and W together and returns OKAY.
  - Required: one AW and one W beat; `resp_valid_o` at N+3 with `resp_err_o` = 0.
- Write with the responder giving awready 3 cycles before wready.
  - Required: awvalid drops after its handshake; wvalid holds until its own; exactly one beat of each.
- Read from 0x04 returning 0x1234_5678 with OKAY, `resp_ready_i` held low for 4 cycles.
  - Required: `resp_rdata_o` = 0x1234_5678 stable throughout; `req_ready_o` = 0 until release.
- Read from 0x3C returning SLVERR.
  - Required: `resp_err_o` = 1.
- Write with the responder returning DECERR.
  - Required: `resp_err_o` = 1.
- `TIMEOUT_CYCLES` = 8, arready held low.
  - Required: `timeout_o` rises after 8 cycles; the transaction completes once arready arrives.
  - Required: `timeout_clr_i` clears the flag.
- `rst_ni` low while awvalid is high.
  - Required: all valids drop without waiting for a clock; `req_ready_o` = 1 after reset.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI-Lite initiator: FSM states,
// response codes and bus widths.
package axil_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } axil_state_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axil_watchdog.sv
// Handshake watchdog: counts stalled bus cycles and raises a sticky flag
// once a single handshake has waited TIMEOUT_CYCLES cycles (0 disables).
module axil_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic kick_i,
    input  logic clr_i,
    output logic flag_o
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] TOP  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          flag_q, flag_d;
    logic          hit;

    // The counter parks at TOP after firing so a long stall sets the flag
    // only once and a later clear is not immediately overridden.
    always_comb begin
        cnt_d = cnt_q;
        hit   = 1'b0;
        if (!run_i || kick_i) begin
            cnt_d = '0;
        end else if (cnt_q != TOP) begin
            cnt_d = cnt_q + 1'b1;
            hit   = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);
        end
        if (hit) begin
            flag_d = 1'b1;
        end else if (clr_i) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/axil_master.sv
// AXI-Lite initiator: one outstanding request/response command at a time,
// translated into AW/W/B or AR/R transactions on the cfg_* bus.
module axil_master
    import axil_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [STRB_W-1:0] req_wstrb_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic              timeout_o,
    input  logic              timeout_clr_i,
    output logic              cfg_awvalid_o,
    input  logic              cfg_awready_i,
    output logic [ADDR_W-1:0] cfg_awaddr_o,
    output logic              cfg_wvalid_o,
    input  logic              cfg_wready_i,
    output logic [DATA_W-1:0] cfg_wdata_o,
    output logic [STRB_W-1:0] cfg_wstrb_o,
    input  logic              cfg_bvalid_i,
    output logic              cfg_bready_o,
    input  logic [1:0]        cfg_bresp_i,
    output logic              cfg_arvalid_o,
    input  logic              cfg_arready_i,
    output logic [ADDR_W-1:0] cfg_araddr_o,
    input  logic              cfg_rvalid_i,
    output logic              cfg_rready_o,
    input  logic [DATA_W-1:0] cfg_rdata_i,
    input  logic [1:0]        cfg_rresp_i
);

    axil_state_e       state_q, state_d;
    logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic              bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic wd_run, wd_kick;

    assign aw_hs = awvalid_q && cfg_awready_i;
    assign w_hs  = wvalid_q  && cfg_wready_i;
    assign b_hs  = bready_q  && cfg_bvalid_i;
    assign ar_hs = arvalid_q && cfg_arready_i;
    assign r_hs  = rready_q  && cfg_rvalid_i;

    always_comb begin
        state_d      = state_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awaddr_d     = awaddr_q;
        araddr_d     = araddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rdata_d      = rdata_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    wdata_d = req_wdata_i;
                    wstrb_d = req_wstrb_i;
                    if (req_we_i) begin
                        awaddr_d  = req_addr_i;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = req_addr_i;
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently; B is only accepted after both.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    bready_d     = 1'b0;
                    rdata_d      = '0;
                    resp_err_d   = resp_is_err(cfg_bresp_i);
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    rready_d     = 1'b0;
                    rdata_d      = cfg_rdata_i;
                    resp_err_d   = resp_is_err(cfg_rresp_i);
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awaddr_q     <= '0;
            araddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awaddr_q     <= awaddr_d;
            araddr_q     <= araddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Watchdog only runs while waiting on the bus; any handshake restarts it.
    assign wd_run  = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                     (state_q == RD_ADDR) || (state_q == RD_DATA);
    assign wd_kick = aw_hs || w_hs || b_hs || ar_hs || r_hs;

    axil_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .run_i (wd_run),
        .kick_i(wd_kick),
        .clr_i (timeout_clr_i),
        .flag_o(timeout_o)
    );

    assign req_ready_o   = (state_q == IDLE);
    assign resp_valid_o  = resp_valid_q;
    assign resp_rdata_o  = rdata_q;
    assign resp_err_o    = resp_err_q;
    assign cfg_awvalid_o = awvalid_q;
    assign cfg_awaddr_o  = awaddr_q;
    assign cfg_wvalid_o  = wvalid_q;
    assign cfg_wdata_o   = wdata_q;
    assign cfg_wstrb_o   = wstrb_q;
    assign cfg_bready_o  = bready_q;
    assign cfg_arvalid_o = arvalid_q;
    assign cfg_araddr_o  = araddr_q;
    assign cfg_rready_o  = rready_q;

endmodule
